// File: rtl/rv32i_types_pkg.sv
// Scalar-side shared types.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/rv32v_types_pkg.sv
// Vector-side shared types: VFU op encodings and lane sequencer state.
package rv32v_types_pkg;

  localparam int unsigned VLMAX  = 32;
  localparam int unsigned VIDX_W = $clog2(VLMAX);
  localparam int unsigned VREG_W = 5;

  typedef enum logic [1:0] {
    VFU_ALU,
    VFU_MUL
  } vfu_t;

  typedef enum logic [2:0] {
    VALU_ADD,
    VALU_SUB,
    VALU_RSB,
    VALU_AND,
    VALU_OR,
    VALU_XOR
  } valuop_t;

  typedef struct packed {
    vfu_t    vfu;
    valuop_t valuop;
  } vexec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } seq_state_t;

  // Writeback pipeline slot: element whose read was issued last cycle.
  typedef struct packed {
    logic              valid;
    logic [VIDX_W-1:0] idx;
  } wb_stage_t;

endpackage

// File: rtl/rv32v_vfu.sv
// Combinational vector functional unit: one 32-bit element per call, byte-gated result.
module rv32v_vfu
  import rv32i_types_pkg::*;
  import rv32v_types_pkg::*;
(
  input  vexec_t     vop,
  input  word_t      opA,
  input  word_t      opB,
  input  logic [3:0] mask_bits,
  output word_t      res
);

  word_t raw;

  // ALU operation select; opA is the vs2 element, opB the vs1 element.
  always_comb begin
    raw = '0;
    if (vop.vfu == VFU_ALU) begin
      case (vop.valuop)
        VALU_ADD: raw = opA + opB;
        VALU_SUB: raw = opA - opB;
        VALU_RSB: raw = opB - opA;
        VALU_AND: raw = opA & opB;
        VALU_OR:  raw = opA | opB;
        VALU_XOR: raw = opA ^ opB;
        default:  raw = '0;
      endcase
    end
  end

  // Zero the bytes of inactive lanes.
  always_comb begin
    res = '0;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask_bits[b] ? raw[8*b +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/rv32v_lane_sequencer.sv
// Element sequencer: walks elements 0..vl-1 through a synchronous RF read,
// the combinational VFU and a v0-masked writeback, one element per cycle.
module rv32v_lane_sequencer
  import rv32i_types_pkg::*;
  import rv32v_types_pkg::*;
#(
  parameter int unsigned MAX_VL = 32,
  parameter int unsigned IDX_W  = $clog2(MAX_VL),
  parameter int unsigned VREG_W = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  vexec_t            vop_in,
  input  logic [VREG_W-1:0] vs1,
  input  logic [VREG_W-1:0] vs2,
  input  logic [VREG_W-1:0] vd,
  input  logic [IDX_W:0]    vl,
  input  logic              vm,
  input  logic [MAX_VL-1:0] v0_mask,
  output logic              busy,
  output logic              done,
  output logic              rf_ren,
  output logic [VREG_W-1:0] rf_rs1,
  output logic [VREG_W-1:0] rf_rs2,
  output logic [IDX_W-1:0]  rf_ridx,
  input  word_t             rf_rdata1,
  input  word_t             rf_rdata2,
  output word_t             vfu_opA,
  output word_t             vfu_opB,
  output vexec_t            vfu_vop,
  output logic [3:0]        vfu_mask_bits,
  input  word_t             vfu_res,
  output logic              rf_wen,
  output logic [VREG_W-1:0] rf_wreg,
  output logic [IDX_W-1:0]  rf_widx,
  output word_t             rf_wdata
);

  localparam logic [IDX_W:0] VlMax = (IDX_W+1)'(MAX_VL);
  localparam logic [IDX_W:0] VlOne = (IDX_W+1)'(1);

  seq_state_t        state_q, state_d;
  vexec_t            op_q, op_d;
  logic [VREG_W-1:0] vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic [IDX_W:0]    vl_q, vl_d;
  logic              vm_q, vm_d;
  logic [IDX_W-1:0]  rd_cnt_q, rd_cnt_d;
  wb_stage_t         wb_q, wb_d;
  // Set for the one cycle after a vl==0 issue: busy and done, but no traffic.
  logic              zdone_q, zdone_d;

  logic           accept;
  logic [IDX_W:0] vl_clamp;
  logic           elem_on;

  // State, operand latches, read counter and writeback slot.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      op_q     <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      vl_q     <= '0;
      vm_q     <= 1'b0;
      rd_cnt_q <= '0;
      wb_q     <= '0;
      zdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      vs1_q    <= vs1_d;
      vs2_q    <= vs2_d;
      vd_q     <= vd_d;
      vl_q     <= vl_d;
      vm_q     <= vm_d;
      rd_cnt_q <= rd_cnt_d;
      wb_q     <= wb_d;
      zdone_q  <= zdone_d;
    end
  end

  // Next state: issue in IDLE, one read per RUN cycle, DRAIN finishes the last write.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    vs1_d      = vs1_q;
    vs2_d      = vs2_q;
    vd_d       = vd_q;
    vl_d       = vl_q;
    vm_d       = vm_q;
    rd_cnt_d   = rd_cnt_q;
    vl_clamp   = (vl > VlMax) ? VlMax : vl;
    // A start during the zero-length done cycle is still "while busy".
    accept     = (state_q == IDLE) && !zdone_q && start;
    zdone_d    = accept && (vl_clamp == '0);
    wb_d.valid = (state_q == RUN);
    wb_d.idx   = rd_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = vop_in;
          vs1_d    = vs1;
          vs2_d    = vs2;
          vd_d     = vd;
          vl_d     = vl_clamp;
          vm_d     = vm;
          rd_cnt_d = '0;
          if (vl_clamp != '0) state_d = RUN;
        end
      end
      RUN: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if ({1'b0, rd_cnt_q} == vl_q - VlOne) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read port, VFU operands and masked writeback; everything idles at zero.
  always_comb begin
    elem_on       = wb_q.valid && (vm_q || v0_mask[wb_q.idx]);
    busy          = (state_q != IDLE) || zdone_q;
    done          = (state_q == DRAIN) || zdone_q;
    rf_ren        = (state_q == RUN);
    rf_rs1        = rf_ren ? vs1_q : '0;
    rf_rs2        = rf_ren ? vs2_q : '0;
    rf_ridx       = rf_ren ? rd_cnt_q : '0;
    vfu_opA       = wb_q.valid ? rf_rdata2 : '0;
    vfu_opB       = wb_q.valid ? rf_rdata1 : '0;
    vfu_vop       = op_q;
    vfu_mask_bits = {4{elem_on}};
    rf_wen        = elem_on;
    rf_wreg       = wb_q.valid ? vd_q : '0;
    rf_widx       = wb_q.valid ? wb_q.idx : '0;
    rf_wdata      = wb_q.valid ? vfu_res : '0;
  end

endmodule

// File: tb/tb_rv32v_lane_sequencer.sv
// Bench for rv32v_lane_sequencer with the real VFU and a behavioural synchronous RF.
module tb_rv32v_lane_sequencer;
  import rv32i_types_pkg::*;
  import rv32v_types_pkg::*;

  localparam logic [31:0] INIT_BASE = 32'hC0DE_0000;

  logic        CLK, nRST, start;
  vexec_t      vop_in;
  logic [4:0]  vs1, vs2, vd;
  logic [5:0]  vl;
  logic        vm;
  logic [31:0] v0_mask;
  logic        busy, done, rf_ren, rf_wen;
  logic [4:0]  rf_rs1, rf_rs2, rf_ridx, rf_wreg, rf_widx;
  word_t       rf_rdata1, rf_rdata2, vfu_opA, vfu_opB, vfu_res, rf_wdata;
  vexec_t      vfu_vop;
  logic [3:0]  vfu_mask_bits;

  // RF preload port, driven by the bench only while the sequencer is idle.
  logic        ld_en;
  logic [4:0]  ld_reg, ld_idx;
  logic [31:0] ld_data;
  logic [31:0] rf_mem [32][32];

  int nvec = 0;
  int nfail = 0;

  rv32v_lane_sequencer dut (
    .CLK(CLK), .nRST(nRST), .start(start), .vop_in(vop_in),
    .vs1(vs1), .vs2(vs2), .vd(vd), .vl(vl), .vm(vm), .v0_mask(v0_mask),
    .busy(busy), .done(done), .rf_ren(rf_ren), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_ridx(rf_ridx), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .vfu_opA(vfu_opA), .vfu_opB(vfu_opB), .vfu_vop(vfu_vop),
    .vfu_mask_bits(vfu_mask_bits), .vfu_res(vfu_res), .rf_wen(rf_wen),
    .rf_wreg(rf_wreg), .rf_widx(rf_widx), .rf_wdata(rf_wdata)
  );

  rv32v_vfu vfu (
    .vop(vfu_vop), .opA(vfu_opA), .opB(vfu_opB), .mask_bits(vfu_mask_bits), .res(vfu_res)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    if (rf_ren) begin
      rf_rdata1 <= rf_mem[rf_rs1][rf_ridx];
      rf_rdata2 <= rf_mem[rf_rs2][rf_ridx];
    end
    if (rf_wen) rf_mem[rf_wreg][rf_widx] <= rf_wdata;
    if (ld_en) rf_mem[ld_reg][ld_idx] <= ld_data;
  end

  typedef struct packed {
    valuop_t           op;
    logic [5:0]        vl;
    logic              vm;
    logic [31:0]       mask;
    logic [3:0][31:0]  a;    // vs2 elements 0..3
    logic [3:0][31:0]  b;    // vs1 elements 0..3
    logic [3:0][31:0]  e;    // vd elements 0..3 after the op
    logic [5:0]        nwr;
    logic              hold; // keep start high while busy
  } vec_t;

  vec_t vecs [7];

  function automatic logic [3:0][31:0] w4(input logic [31:0] x0, input logic [31:0] x1,
                                          input logic [31:0] x2, input logic [31:0] x3);
    logic [3:0][31:0] r;
    r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3;
    return r;
  endfunction

  function automatic logic [31:0] init(input int i);
    return INIT_BASE + 32'(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic poke(input int r, input int i, input logic [31:0] d);
    ld_en = 1'b1; ld_reg = 5'(r); ld_idx = 5'(i); ld_data = d;
    @(posedge CLK); #1;
    ld_en = 1'b0;
  endtask

  // Issue one op from an idle cycle and check its cycle-level behaviour.
  // Returns in the idle cycle right after done.
  task automatic run_op(input valuop_t op, input int s1, input int s2, input int d,
                        input int l, input logic m, input logic [31:0] msk,
                        input bit hold, input int exp_wr);
    int vle, nren, nwen, nbusy, done_at, first_ren, bad_ridx, bad_widx, bad_aux;
    logic [31:0] idle_opnds;
    vle = (l > 32) ? 32 : l;
    nren = 0; nwen = 0; nbusy = 0; done_at = -1; first_ren = -1;
    bad_ridx = 0; bad_widx = 0; bad_aux = 0; idle_opnds = '0;
    vop_in.vfu = VFU_ALU; vop_in.valuop = op;
    vs1 = 5'(s1); vs2 = 5'(s2); vd = 5'(d); vl = 6'(l); vm = m; v0_mask = msk;
    start = 1'b1;
    @(posedge CLK); #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= 80 && done_at < 0; c++) begin
      if (c == 1) idle_opnds = vfu_opA | vfu_opB | 32'(vfu_mask_bits);
      if (busy) nbusy++;
      if (rf_ren) begin
        nren++;
        if (first_ren < 0) first_ren = c;
        if (int'(rf_ridx) != c - 1 || int'(rf_rs1) != s1 || int'(rf_rs2) != s2) bad_ridx++;
      end
      if (rf_wen) begin
        nwen++;
        if (int'(rf_widx) != c - 2 || int'(rf_wreg) != d) bad_widx++;
      end
      if (vfu_mask_bits != {4{rf_wen}}) bad_aux++;
      if (rf_wen && vfu_vop.valuop != op) bad_aux++;
      if (done) begin
        done_at = c;
        start = 1'b0;
      end else begin
        @(posedge CLK); #1;
      end
    end
    start = 1'b0;
    chk("done_cycle", 32'(done_at), 32'((vle == 0) ? 1 : vle + 1));
    chk("busy_cycles", 32'(nbusy), 32'((vle == 0) ? 1 : vle + 1));
    chk("read_count", 32'(nren), 32'(vle));
    chk("write_count", 32'(nwen), 32'(exp_wr));
    if (vle > 0) chk("first_read_cycle", 32'(first_ren), 32'd1);
    chk("read_index_seq", 32'(bad_ridx), 32'd0);
    chk("write_index_seq", 32'(bad_widx), 32'd0);
    chk("vfu_mask_vop", 32'(bad_aux), 32'd0);
    chk("idle_vfu_operands", idle_opnds, 32'd0);
    @(posedge CLK); #1;
    chk("after_done_quiet", {28'd0, busy, done, rf_ren, rf_wen}, 32'd0);
  endtask

  int nbad;
  int nact;

  initial begin
    vecs[0] = '{op: VALU_ADD, vl: 6'd4, vm: 1'b1, mask: 32'h0, a: w4(1, 2, 3, 4),
                b: w4(10, 20, 30, 40), e: w4(11, 22, 33, 44), nwr: 6'd4, hold: 1'b1};
    vecs[1] = '{op: VALU_SUB, vl: 6'd4, vm: 1'b0, mask: 32'h5, a: w4(100, 200, 300, 400),
                b: w4(1, 2, 3, 4), e: w4(99, init(1), 297, init(3)), nwr: 6'd2, hold: 1'b0};
    vecs[2] = '{op: VALU_ADD, vl: 6'd0, vm: 1'b1, mask: 32'h0, a: w4(1, 1, 1, 1),
                b: w4(2, 2, 2, 2), e: w4(init(0), init(1), init(2), init(3)), nwr: 6'd0,
                hold: 1'b1};
    vecs[3] = '{op: VALU_RSB, vl: 6'd2, vm: 1'b1, mask: 32'h0, a: w4(5, 6, 7, 8),
                b: w4(50, 60, 70, 80), e: w4(45, 54, init(2), init(3)), nwr: 6'd2, hold: 1'b0};
    vecs[4] = '{op: VALU_ADD, vl: 6'd3, vm: 1'b0, mask: 32'hFFFF_FFFA, a: w4(1, 2, 3, 4),
                b: w4(1, 1, 1, 1), e: w4(init(0), 3, init(2), init(3)), nwr: 6'd1, hold: 1'b0};
    vecs[5] = '{op: VALU_SUB, vl: 6'd1, vm: 1'b1, mask: 32'h0, a: w4(0, 0, 0, 0),
                b: w4(1, 1, 1, 1), e: w4(32'hFFFF_FFFF, init(1), init(2), init(3)),
                nwr: 6'd1, hold: 1'b0};
    vecs[6] = '{op: VALU_XOR, vl: 6'd4, vm: 1'b1, mask: 32'h0,
                a: w4(32'hF0F0_F0F0, 0, 32'hFFFF_FFFF, 32'h1234_5678),
                b: w4(32'h0F0F_0F0F, 0, 32'hFFFF_FFFF, 32'h0000_FFFF),
                e: w4(32'hFFFF_FFFF, 0, 0, 32'h1234_A987), nwr: 6'd4, hold: 1'b0};

    nRST = 1'b0; start = 1'b0; vop_in = '0; vs1 = '0; vs2 = '0; vd = '0; vl = '0;
    vm = 1'b0; v0_mask = '0; ld_en = 1'b0; ld_reg = '0; ld_idx = '0; ld_data = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
    chk("reset_rf_ctl", {30'd0, rf_ren, rf_wen}, 32'd0);
    chk("reset_vfu_opA", vfu_opA, 32'd0);
    chk("reset_vfu_mask", 32'(vfu_mask_bits), 32'd0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Table: vs1=r1, vs2=r2, vd=r3; r3 preset so untouched elements are visible.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++) begin
        poke(1, i, vecs[v].b[i]);
        poke(2, i, vecs[v].a[i]);
      end
      for (int i = 0; i < 5; i++) poke(3, i, init(i));
      run_op(vecs[v].op, 1, 2, 3, int'(vecs[v].vl), vecs[v].vm, vecs[v].mask,
             vecs[v].hold, int'(vecs[v].nwr));
      for (int i = 0; i < 4; i++) chk($sformatf("v%0d_vd%0d", v, i), rf_mem[3][i], vecs[v].e[i]);
      chk($sformatf("v%0d_tail", v), rf_mem[3][4], init(4));
    end

    // Back-to-back, the second op consuming the first op's result.
    poke(8, 0, 50); poke(8, 1, 60); poke(9, 0, 5); poke(9, 1, 6);
    run_op(VALU_RSB, 8, 9, 10, 2, 1'b1, 32'h0, 1'b0, 2);
    run_op(VALU_ADD, 10, 9, 11, 2, 1'b1, 32'h0, 1'b0, 2);
    chk("b2b_first_0", rf_mem[10][0], 32'd45);
    chk("b2b_first_1", rf_mem[10][1], 32'd54);
    chk("b2b_second_0", rf_mem[11][0], 32'd50);
    chk("b2b_second_1", rf_mem[11][1], 32'd60);

    // vd == vs2 over a full register, then again with vl clamped from 40.
    for (int i = 0; i < 32; i++) begin
      poke(5, i, 32'(i * 7));
      poke(6, i, 32'd1);
    end
    run_op(VALU_ADD, 6, 5, 5, 32, 1'b1, 32'h0, 1'b0, 32);
    nbad = 0;
    for (int i = 0; i < 32; i++) if (rf_mem[5][i] !== 32'(i * 7 + 1)) nbad++;
    chk("inplace_inc_once", 32'(nbad), 32'd0);
    run_op(VALU_ADD, 6, 5, 5, 40, 1'b1, 32'h0, 1'b0, 32);
    nbad = 0;
    for (int i = 0; i < 32; i++) if (rf_mem[5][i] !== 32'(i * 7 + 2)) nbad++;
    chk("clamped_inc_twice", 32'(nbad), 32'd0);

    // Reset in the cycle of element 1's writeback: element 0 only survives.
    for (int i = 0; i < 8; i++) begin
      poke(12, i, 32'(i));
      poke(13, i, 32'd100);
      poke(14, i, init(i));
    end
    vop_in.vfu = VFU_ALU; vop_in.valuop = VALU_ADD;
    vs1 = 5'd12; vs2 = 5'd13; vd = 5'd14; vl = 6'd8; vm = 1'b1; v0_mask = '0;
    start = 1'b1;
    @(posedge CLK); #1;   // T+1
    start = 1'b0;
    @(posedge CLK); #1;   // T+2
    chk("pre_abort_write", {31'd0, rf_wen}, 32'd1);
    @(posedge CLK); #1;   // T+3
    nRST = 1'b0;
    #1;
    chk("abort_ctl_zero", {28'd0, busy, done, rf_ren, rf_wen}, 32'd0);
    chk("abort_data_zero", vfu_opA | vfu_opB | rf_wdata, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    nact = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK); #1;
      if (busy || done || rf_wen || rf_ren) nact++;
    end
    chk("abort_no_activity", 32'(nact), 32'd0);
    chk("abort_elem0", rf_mem[14][0], 32'd100);
    nbad = 0;
    for (int i = 1; i < 8; i++) if (rf_mem[14][i] !== init(i)) nbad++;
    chk("abort_rest_untouched", 32'(nbad), 32'd0);
    run_op(VALU_ADD, 12, 13, 14, 8, 1'b1, 32'h0, 1'b0, 8);
    nbad = 0;
    for (int i = 0; i < 8; i++) if (rf_mem[14][i] !== 32'(100 + i)) nbad++;
    chk("after_abort_rerun", 32'(nbad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
